// File: rtl/move_queue.sv
// Purpose: 64-bit move-entry FIFO. Entries are written over Wishbone and drained by a pull/avail consumer.
// Latency: a pushed entry appears on mq_data/mq_avail one cycle after the push. Register reads are combinational and wb_ack_o is held at 1.
// Backpressure: a push while full is dropped and sets a sticky overflow flag, unless a pull is accepted in the same cycle.
// Option: define MOVE_QUEUE_STATS_EN to add a saturating accepted-push counter, readable at adr 3.
module move_queue #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] mq_data,
    output logic        mq_avail,
    input  logic        mq_pull,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   staging_q, staging_d;

    logic wr_en, flush, clr_ovf, push_req, stage_wr;
    logic full, empty, pull_acc, push_acc;
    logic [15:0] stat_rd;

    // Bus write decode and push/pull acceptance
    always_comb begin
        wr_en    = wb_cyc_i && wb_stb_i && wb_we_i;
        stage_wr = wr_en && (wb_adr_i == 4'd0);
        push_req = wr_en && (wb_adr_i == 4'd1);
        flush    = wr_en && (wb_adr_i == 4'd2) && wb_dat_i[0];
        clr_ovf  = wr_en && (wb_adr_i == 4'd2) && wb_dat_i[1];
        full     = (level_q == LVL_FULL);
        empty    = (level_q == '0);
        pull_acc = mq_pull && !empty;
        // When full, a push is accepted only if the head frees a slot this cycle
        push_acc = push_req && (!full || pull_acc);
    end

    // Next-state for pointers, level, overflow flag and staging register; flush wins over push/pull
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        staging_d = staging_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (pull_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            case ({push_acc, pull_acc})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
        if (clr_ovf)
            ovf_d = 1'b0;
        else if (push_req && !push_acc)
            ovf_d = 1'b1;
        if (stage_wr) staging_d = wb_dat_i;
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            staging_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            staging_q <= staging_d;
        end
    end

    // Entry storage is not reset; level and pointers alone define validity
    always_ff @(posedge clk) begin
        if (push_acc && !flush) mem_q[wr_ptr_q] <= {wb_dat_i, staging_q};
    end

`ifdef MOVE_QUEUE_STATS_EN
    logic [15:0] stat_cnt_q, stat_cnt_d;

    // Accepted-push counter that saturates at 0xffff and is cleared by flush
    always_comb begin
        stat_cnt_d = stat_cnt_q;
        if (flush)
            stat_cnt_d = '0;
        else if (push_acc && (stat_cnt_q != 16'hffff))
            stat_cnt_d = stat_cnt_q + 16'd1;
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stat_cnt_q <= '0;
        else      stat_cnt_q <= stat_cnt_d;
    end

    assign stat_rd = stat_cnt_q;
`else
    assign stat_rd = '0;
`endif

    assign mq_avail = !empty;
    assign mq_data  = mem_q[rd_ptr_q];
    assign wb_ack_o = 1'b1;

    // Register read mux
    always_comb begin
        wb_dat_o = '0;
        case (wb_adr_i)
            4'd0: begin
                wb_dat_o[8:0] = 9'(level_q);
                wb_dat_o[16]  = full;
                wb_dat_o[17]  = empty;
                wb_dat_o[24]  = ovf_q;
            end
            4'd1:    wb_dat_o = staging_q;
            4'd3:    wb_dat_o = {16'h0000, stat_rd};
            default: wb_dat_o = '0;
        endcase
    end
endmodule

// File: tb/tb_move_queue.sv
// Self-checking bench for move_queue. The reference model is a queue of entries plus a staging word, an overflow bit and a push count.
// Inputs are driven on the falling edge. Outputs are sampled shortly after the rising edge.
`timescale 1ns/100ps
module tb_move_queue;
    localparam int DEPTH = 16;
`ifdef MOVE_QUEUE_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] mq_data;
    logic        mq_avail;
    logic        mq_pull;
    logic        wb_stb_i, wb_cyc_i, wb_we_i;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    int vectors = 0;
    int miscompares = 0;

    // reference model
    logic [63:0] m_q[$];
    logic [31:0] m_stage;
    bit          m_ovf;
    int          m_stat;

    move_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .mq_data(mq_data), .mq_avail(mq_avail), .mq_pull(mq_pull),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        logic [8:0]  lvl;
        s = '0;
        lvl = 9'(m_q.size());
        s[8:0] = lvl;
        s[16]  = (m_q.size() == DEPTH);
        s[17]  = (m_q.size() == 0);
        s[24]  = m_ovf;
        return s;
    endfunction

    function automatic logic [31:0] exp_stats();
        return STATS_EN ? 32'(m_stat) : 32'd0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_stage = '0;
        m_ovf   = 1'b0;
        m_stat  = 0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        wb_adr_i = a;
        #0.2;
        v = wb_dat_o;
    endtask

    // One bus/consumer cycle, followed by the model update
    task automatic cycle(input bit cyc, input bit stb, input bit we, input logic [3:0] adr,
                         input logic [31:0] dat, input bit pull);
        bit wr;
        @(negedge clk);
        wb_cyc_i = cyc; wb_stb_i = stb; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; mq_pull = pull;
        @(posedge clk);
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; mq_pull = 1'b0;
        wr = cyc && stb && we;
        if (wr && adr == 4'd2 && dat[0]) begin
            m_q.delete();
            m_stat = 0;
        end else begin
            if (pull && m_q.size() > 0) void'(m_q.pop_front());
            if (wr && adr == 4'd1) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back({dat, m_stage});
                    if (m_stat < 65535) m_stat++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (wr && adr == 4'd2 && dat[1]) m_ovf = 1'b0;
        if (wr && adr == 4'd0) m_stage = dat;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
        cycle(1'b1, 1'b1, 1'b1, adr, dat, 1'b0);
    endtask

    task automatic push(input logic [63:0] e);
        wr(4'd0, e[31:0]);
        wr(4'd1, e[63:32]);
    endtask

    task automatic idle(input bit pull);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, pull);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b0;
        #12;
        model_reset();
        vectors++;
        if (mq_avail !== 1'b0) begin miscompares++; $display("FAIL reset_avail got %b exp 0", mq_avail); end
        vectors++;
        if (wb_ack_o !== 1'b1) begin miscompares++; $display("FAIL reset_ack got %b exp 1", wb_ack_o); end
        rd(4'd0, v); vectors++;
        if (v !== 32'h00020000) begin miscompares++; $display("FAIL reset_status got %h exp 00020000", v); end
        rd(4'd1, v); vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL reset_staging got %h exp 0", v); end
        rd(4'd3, v); vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL reset_stats got %h exp 0", v); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic_push();
        logic [31:0] v;
        wr(4'd0, 32'h0005fffe);
        wr(4'd1, 32'h00001000);
        vectors++;
        if (mq_avail !== 1'b1) begin miscompares++; $display("FAIL basic_avail got %b exp 1", mq_avail); end
        vectors++;
        if (mq_data !== 64'h000010000005fffe) begin miscompares++; $display("FAIL basic_data got %h exp 000010000005fffe", mq_data); end
        rd(4'd0, v); vectors++;
        if (v !== 32'h00000001) begin miscompares++; $display("FAIL basic_status got %h exp 00000001", v); end
        rd(4'd1, v); vectors++;
        if (v !== 32'h0005fffe) begin miscompares++; $display("FAIL basic_staging got %h exp 0005fffe", v); end
        wr(4'd2, 32'h1);
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        logic [63:0] first;
        first = rnd64();
        push(first);
        for (int i = 1; i < DEPTH; i++) push(rnd64());
        rd(4'd0, v); vectors++;
        if (v !== 32'h00010010) begin miscompares++; $display("FAIL ovf_full_status got %h exp 00010010", v); end
        push(rnd64());
        rd(4'd0, v); vectors++;
        if (v !== 32'h01010010) begin miscompares++; $display("FAIL ovf_set_status got %h exp 01010010", v); end
        vectors++;
        if (mq_data !== first) begin miscompares++; $display("FAIL ovf_head got %h exp %h", mq_data, first); end
        wr(4'd7, 32'hffffffff);
        rd(4'd0, v); vectors++;
        if (v !== 32'h01010010) begin miscompares++; $display("FAIL ovf_unlisted_adr got %h exp 01010010", v); end
        wr(4'd2, 32'h2);
        rd(4'd0, v); vectors++;
        if (v !== 32'h00010010) begin miscompares++; $display("FAIL ovf_clear_status got %h exp 00010010", v); end
        vectors++;
        if (mq_data !== first) begin miscompares++; $display("FAIL ovf_clear_head got %h exp %h", mq_data, first); end
    endtask

    task automatic test_full_push_pull();
        logic [31:0] v;
        logic [63:0] new_e, last;
        new_e = rnd64();
        last  = '0;
        wr(4'd0, new_e[31:0]);
        cycle(1'b1, 1'b1, 1'b1, 4'd1, new_e[63:32], 1'b1);
        rd(4'd0, v); vectors++;
        if (v !== 32'h00010010) begin miscompares++; $display("FAIL fpp_status got %h exp 00010010", v); end
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (mq_data !== m_q[0]) begin miscompares++; $display("FAIL fpp_drain[%0d] got %h exp %h", i, mq_data, m_q[0]); end
            last = mq_data;
            idle(1'b1);
        end
        vectors++;
        if (last !== new_e) begin miscompares++; $display("FAIL fpp_last got %h exp %h", last, new_e); end
        vectors++;
        if (mq_avail !== 1'b0) begin miscompares++; $display("FAIL fpp_empty_avail got %b exp 0", mq_avail); end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        logic [63:0] e;
        wr(4'd2, 32'h1);
        for (int i = 0; i < 3; i++) push(rnd64());
        for (int i = 0; i < 20; i++) begin
            e = rnd64();
            wr(4'd0, e[31:0]);
            vectors++;
            if (mq_data !== m_q[0]) begin miscompares++; $display("FAIL wrap_head[%0d] got %h exp %h", i, mq_data, m_q[0]); end
            cycle(1'b1, 1'b1, 1'b1, 4'd1, e[63:32], 1'b1);
            rd(4'd0, v); vectors++;
            if (v !== 32'h00000003) begin miscompares++; $display("FAIL wrap_level[%0d] got %h exp 00000003", i, v); end
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (mq_data !== m_q[0]) begin miscompares++; $display("FAIL wrap_drain[%0d] got %h exp %h", i, mq_data, m_q[0]); end
            idle(1'b1);
        end
    endtask

    task automatic test_flush_reset();
        logic [31:0] v;
        for (int i = 0; i < 3; i++) push(rnd64());
        rd(4'd0, v); vectors++;
        if (v !== 32'h00000003) begin miscompares++; $display("FAIL flush_pre_level got %h exp 00000003", v); end
        cycle(1'b1, 1'b1, 1'b1, 4'd2, 32'h1, 1'b1);
        vectors++;
        if (mq_avail !== 1'b0) begin miscompares++; $display("FAIL flush_avail got %b exp 0", mq_avail); end
        rd(4'd0, v); vectors++;
        if (v !== 32'h00020000) begin miscompares++; $display("FAIL flush_status got %h exp 00020000", v); end
        for (int i = 0; i < 5; i++) push(rnd64());
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (mq_avail !== 1'b0) begin miscompares++; $display("FAIL rst_mid_avail got %b exp 0", mq_avail); end
        rd(4'd0, v); vectors++;
        if (v !== 32'h00020000) begin miscompares++; $display("FAIL rst_mid_status got %h exp 00020000", v); end
        rd(4'd1, v); vectors++;
        if (v !== 32'h0) begin miscompares++; $display("FAIL rst_mid_staging got %h exp 0", v); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_stats();
        logic [31:0] v;
        wr(4'd2, 32'h1);
        for (int i = 0; i < 5; i++) push(rnd64());
        rd(4'd3, v); vectors++;
        if (v !== (STATS_EN ? 32'd5 : 32'd0)) begin miscompares++; $display("FAIL stats_five got %h exp %h", v, STATS_EN ? 32'd5 : 32'd0); end
        wr(4'd2, 32'h1);
        rd(4'd3, v); vectors++;
        if (v !== 32'd0) begin miscompares++; $display("FAIL stats_flushed got %h exp 0", v); end
    endtask

    task automatic test_random();
        logic [31:0] v;
        int op;
        bit pull;
        logic [31:0] d;
        for (int i = 0; i < 400; i++) begin
            op   = $urandom_range(0, 9);
            d    = $urandom();
            pull = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            if (m_q.size() > 0) begin
                vectors++;
                if (mq_data !== m_q[0]) begin miscompares++; $display("FAIL rnd_head[%0d] got %h exp %h", i, mq_data, m_q[0]); end
            end
            case (op)
                0, 1, 2: cycle(1'b1, 1'b1, 1'b1, 4'd0, d, pull);
                3, 4, 5: cycle(1'b1, 1'b1, 1'b1, 4'd1, d, pull);
                6:       cycle(1'b1, 1'b1, 1'b1, 4'd2, {30'h0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0}, pull);
                7:       cycle(1'b1, 1'b1, 1'b1, 4'($urandom_range(3, 15)), d, pull);
                8:       cycle($urandom_range(0, 1) == 1, 1'b1, 1'b0, 4'($urandom_range(0, 2)), d, pull);
                default: idle(pull);
            endcase
            vectors++;
            if (mq_avail !== (m_q.size() != 0)) begin miscompares++; $display("FAIL rnd_avail[%0d] got %b exp %b", i, mq_avail, m_q.size() != 0); end
            rd(4'd0, v); vectors++;
            if (v !== exp_status()) begin miscompares++; $display("FAIL rnd_status[%0d] got %h exp %h", i, v, exp_status()); end
            rd(4'd1, v); vectors++;
            if (v !== m_stage) begin miscompares++; $display("FAIL rnd_staging[%0d] got %h exp %h", i, v, m_stage); end
            rd(4'd3, v); vectors++;
            if (v !== exp_stats()) begin miscompares++; $display("FAIL rnd_stats[%0d] got %h exp %h", i, v, exp_stats()); end
        end
    endtask

    initial begin
        rst = 1'b0;
        mq_pull = 1'b0;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = 4'd0; wb_dat_i = 32'd0;
        model_reset();
        test_reset();
        test_basic_push();
        test_overflow();
        test_full_push_pull();
        test_wrap();
        test_flush_reset();
        test_stats();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
